// File: rtl/amy_ahb_pkg.sv
// Shared AHB-lite constants, arbiter state encoding and byte-lane helper
// for the program ROM port arbiter.
package amy_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {IDLE, ISSUE, RESP, ERR1, ERR2} arb_state_t;

    // Attributes of one captured address phase (address is kept separately
    // because its width depends on the ROM size).
    typedef struct packed {
        logic       valid;
        logic       err;
        logic       write;
        logic [2:0] size;
    } req_attr_t;

    // Byte enables for a transfer of the given size at the given byte offset.
    function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] offset);
        case (size)
            HSIZE_BYTE: be_decode = 4'b0001 << offset;
            HSIZE_HALF: be_decode = 4'b0011 << offset;
            default:    be_decode = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rom_arb_port_capture.sv
// One AHB-lite slave port of the ROM arbiter: captures an address phase,
// decodes it for errors, holds it pending and drives hready_out/hresp.
module rom_arb_port_capture
    import amy_ahb_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter bit WR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hready_in,
    input  logic              done,        // this port's RESP or ERR2 cycle
    input  logic              err_active,  // this port's ERR1 or ERR2 cycle
    output logic              hready_out,
    output logic              hresp,
    output logic              pend_write,
    output req_attr_t         nxt,         // pending attributes after this edge
    output logic [MEM_AW+1:0] nxt_addr     // pending byte address after this edge
);

    req_attr_t         pend;
    logic [MEM_AW+1:0] pend_addr;
    logic              capture;
    logic              addr_err;
    logic              size_err;
    logic              align_err;
    logic              write_err;

    // The port stalls while it owns a pending request, except in the cycle
    // its response completes, where the next address phase may be taken.
    assign hready_out = !pend.valid || done;
    assign hresp      = err_active;
    assign pend_write = pend.write;

    assign capture   = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                       && hready_in && hready_out;
    assign addr_err  = (haddr >> (MEM_AW + 2)) != 32'd0;
    assign size_err  = hsize > HSIZE_WORD;
    assign align_err = (hsize == HSIZE_HALF && haddr[0])
                       || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
    assign write_err = hwrite && !WR_EN;

    // Next pending request: cleared on completion, replaced on capture.
    always_comb begin
        // NOTE: defaults first so every path assigns nxt/nxt_addr; a missing
        // assignment in always_comb would otherwise infer a latch.
        nxt      = pend;
        nxt_addr = pend_addr;
        if (done) begin
            nxt.valid = 1'b0;
        end
        if (capture) begin
            nxt.valid = 1'b1;
            nxt.err   = addr_err || size_err || align_err || write_err;
            nxt.write = hwrite;
            nxt.size  = hsize;
            nxt_addr  = haddr[MEM_AW+1:0];
        end
    end

    // Pending request registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pend      <= '0;
            pend_addr <= '0;
        end else begin
            pend      <= nxt;
            pend_addr <= nxt_addr;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port program ROM between the CPU (M0) and the EMU debug
// port (M1). One memory access at a time, round-robin on simultaneous requests.
module rom_port_arbiter
    import amy_ahb_pkg::*;
#(
    parameter int MEM_AW    = 12,
    parameter int DW        = 32,
    parameter bit CPU_WR_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_hsel,
    input  logic [31:0]       m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [DW-1:0]     m0_hwdata,
    input  logic              m0_hready_in,
    output logic              m0_hready_out,
    output logic              m0_hresp,
    output logic [DW-1:0]     m0_hrdata,
    input  logic              m1_hsel,
    input  logic [31:0]       m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [DW-1:0]     m1_hwdata,
    input  logic              m1_hready_in,
    output logic              m1_hready_out,
    output logic              m1_hresp,
    output logic [DW-1:0]     m1_hrdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    arb_state_t        state;
    logic              grant;       // 0 = M0, 1 = M1
    logic              last_grant;  // winner of the most recent tie
    req_attr_t         nxt0, nxt1, sel;
    logic [MEM_AW+1:0] nxt0_addr, nxt1_addr, sel_addr;
    logic              pend0_write, pend1_write;
    logic              tie, pick;
    logic              resp_phase, err_phase;

    assign resp_phase = (state == RESP) || (state == ERR2);
    assign err_phase  = (state == ERR1) || (state == ERR2);

    rom_arb_port_capture #(.MEM_AW(MEM_AW), .WR_EN(CPU_WR_EN)) u_port0 (
        .clk(clk), .rst_n(rst_n),
        .hsel(m0_hsel), .haddr(m0_haddr), .htrans(m0_htrans), .hwrite(m0_hwrite),
        .hsize(m0_hsize), .hready_in(m0_hready_in),
        .done(resp_phase && !grant), .err_active(err_phase && !grant),
        .hready_out(m0_hready_out), .hresp(m0_hresp), .pend_write(pend0_write),
        .nxt(nxt0), .nxt_addr(nxt0_addr)
    );

    rom_arb_port_capture #(.MEM_AW(MEM_AW), .WR_EN(1'b1)) u_port1 (
        .clk(clk), .rst_n(rst_n),
        .hsel(m1_hsel), .haddr(m1_haddr), .htrans(m1_htrans), .hwrite(m1_hwrite),
        .hsize(m1_hsize), .hready_in(m1_hready_in),
        .done(resp_phase && grant), .err_active(err_phase && grant),
        .hready_out(m1_hready_out), .hresp(m1_hresp), .pend_write(pend1_write),
        .nxt(nxt1), .nxt_addr(nxt1_addr)
    );

    // Pick the next requester. The tie pointer only moves on real ties, so the
    // loser of a tie is guaranteed to win the next one.
    always_comb begin
        tie      = nxt0.valid && nxt1.valid;
        pick     = tie ? !last_grant : nxt1.valid;
        sel      = pick ? nxt1 : nxt0;
        sel_addr = pick ? nxt1_addr : nxt0_addr;
    end

    // Arbiter FSM with registered memory command outputs. Decisions use the
    // next-cycle pending view so a fresh capture reaches the ROM one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
        end else begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_be   <= '0;
            case (state)
                IDLE, RESP, ERR2: begin
                    if (nxt0.valid || nxt1.valid) begin
                        grant <= pick;
                        if (tie) begin
                            last_grant <= pick;
                        end
                        if (sel.err) begin
                            state <= ERR1;
                        end else begin
                            state    <= ISSUE;
                            mem_cs   <= 1'b1;
                            mem_we   <= sel.write;
                            mem_addr <= sel_addr[MEM_AW+1:2];
                            mem_be   <= be_decode(sel.size, sel_addr[1:0]);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE:   state <= RESP;
                ERR1:    state <= ERR2;
                default: state <= IDLE;
            endcase
        end
    end

    // Write data belongs to the data phase, which the stalled master holds
    // stable, so it is steered straight from the granted port.
    assign mem_wdata = (state == ISSUE && mem_we) ? (grant ? m1_hwdata : m0_hwdata) : '0;

    // Read data is only presented to the granted port in its RESP cycle.
    assign m0_hrdata = (state == RESP && !grant && !pend0_write) ? mem_rdata : '0;
    assign m1_hrdata = (state == RESP &&  grant && !pend1_write) ? mem_rdata : '0;

endmodule
